prog_fifo: RTL

PROG_FIFO -- requirements
Module: prog_fifo

---
 rtl/fifo_pkg.sv | 8 +
 rtl/prog_fifo_if.sv | 28 ++
 rtl/fifo_mem.sv | 19 +
 rtl/prog_fifo.sv | 65 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and read-mode enum for the programmable FIFO.
package fifo_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_AF_THRESH = DEF_DEPTH - 1;
  localparam int DEF_AE_THRESH = 1;
  typedef enum logic {STD, FWFT} fifo_mode_e;
endpackage

// File: rtl/prog_fifo_if.sv
// prog_fifo_if: write/read handshake, data and status bundle of the FIFO.
interface prog_fifo_if
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH
);
  logic [FIFO_WIDTH-1:0]       data_in;
  logic                        wr_en;
  logic                        rd_en;
  logic [FIFO_WIDTH-1:0]       data_out;
  logic                        wr_ack;
  logic                        overflow;
  logic                        underflow;
  logic                        full;
  logic                        empty;
  logic                        almostfull;
  logic                        almostempty;
  logic [$clog2(FIFO_DEPTH):0] count;
  modport master (
    output data_in, wr_en, rd_en,
    input  data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );
  modport slave (
    input  data_in, wr_en, rd_en,
    output data_out, wr_ack, overflow, underflow, full, empty, almostfull, almostempty, count
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(FIFO_DEPTH)-1:0] waddr,
  input  logic [FIFO_WIDTH-1:0]         wdata,
  input  logic [$clog2(FIFO_DEPTH)-1:0] raddr,
  output logic [FIFO_WIDTH-1:0]         rdata
);
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prog_fifo.sv
// prog_fifo: synchronous FIFO with programmable almost flags and
// selectable standard or first-word-fall-through read timing.
module prog_fifo #(
  parameter int FIFO_WIDTH = fifo_pkg::DEF_WIDTH,
  parameter int FIFO_DEPTH = fifo_pkg::DEF_DEPTH,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = fifo_pkg::DEF_AE_THRESH,
  parameter bit FWFT       = 1'b0
) (
  input logic        clk,
  input logic        rst,
  prog_fifo_if.slave bus
);
  import fifo_pkg::*;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam fifo_mode_e MODE = FWFT ? fifo_pkg::FWFT : STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C = CW'(AE_THRESH);
  if (FIFO_WIDTH < 1 || FIFO_WIDTH > 64 || FIFO_DEPTH < 4 || FIFO_DEPTH > 1024 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || AF_THRESH < 1 || AF_THRESH > FIFO_DEPTH - 1 ||
      AE_THRESH < 1 || AE_THRESH > FIFO_DEPTH - 1) begin : g_bad_params
    $error("prog_fifo: illegal parameter combination");
  end
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [FIFO_WIDTH-1:0] rd_data, data_q;
  logic                  rd_ok, wr_ok;
  assign bus.full        = count == DEPTH_C;
  assign bus.empty       = count == '0;
  assign bus.almostfull  = count >= AF_C && !bus.full;
  assign bus.almostempty = count <= AE_C && !bus.empty;
  assign bus.count       = count;
  // a full FIFO can still take a write when a read frees a slot this cycle
  assign rd_ok = bus.rd_en && !bus.empty;
  assign wr_ok = bus.wr_en && (!bus.full || rd_ok);
  assign bus.data_out = MODE == fifo_pkg::FWFT ? (bus.empty ? '0 : rd_data) : data_q;
  fifo_mem #(.FIFO_WIDTH(FIFO_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr),
    .wdata(bus.data_in),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      data_q        <= '0;
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + AW'(wr_ok);
      rd_ptr        <= rd_ptr + AW'(rd_ok);
      count         <= count + CW'(wr_ok) - CW'(rd_ok);
      data_q        <= rd_ok ? rd_data : data_q;
      bus.wr_ack    <= wr_ok;
      bus.overflow  <= bus.wr_en && !wr_ok;
      bus.underflow <= bus.rd_en && bus.empty;
    end
endmodule
